mem_access_ctrl: RTL and testbench

//  Sequences the MEM stage: turns MemRead/MemWrite + funct3 from the main decoder into one
//  bus transaction with a req/ack handshake. Stalls the pipeline until the bus completes.

---
 rtl/mem_access_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Sequences the MEM stage of the core. A load or store coming out of EX/MEM is
// turned into exactly one bus transaction using a req/ack handshake. The
// pipeline is held until that transaction completes. This block also produces:
//   - byte enables,
//   - store lane replication,
//   - load byte/half extraction with sign or zero extension.
// It reports misaligned accesses, illegal widths, bus errors and timeouts to
// the exception logic.
//
// State flow: IDLE -> REQ -> DONE -> IDLE. Checks that fail in IDLE go
// straight to DONE without issuing a bus cycle. DONE is a single cycle with
// stall released, so the pipeline can retire the finished instruction.
//
// Parameters
//   TIMEOUT        cycles allowed in REQ before the access is abandoned
//                  (0 disables the timeout)
//
// Ports
//   clk_i          core clock
//   rst_n_i        asynchronous active-low reset
//   mem_read_i     load request
//   mem_write_i    store request (wins if both are set)
//   funct3_i       width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr_i         effective byte address
//   wdata_i        store data, low-aligned
//   flush_i        kill the current MEM instruction
//   stall_o        hold IF..MEM stages
//   rdata_o        extended load result (holds between pulses)
//   rdata_valid_o  one-cycle pulse, rdata_o updated
//   misalign_o     one-cycle pulse, misaligned access, no bus cycle
//   fault_o        one-cycle pulse, illegal funct3, bus error or timeout
//   bus_req_o      bus request, held until ack/err/timeout
//   bus_we_o       1 = write
//   bus_addr_o     word-aligned address
//   bus_wdata_o    lane-replicated store data
//   bus_be_o       byte enables
//   bus_ack_i      transaction complete, bus_rdata_i valid this cycle
//   bus_err_i      transaction failed (same timing as ack)
//   bus_rdata_i    read data word
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        misalign_o,
  output logic        fault_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_ack_i,
  input  logic        bus_err_i,
  input  logic [31:0] bus_rdata_i
);

  // The counter must be able to hold TIMEOUT itself. It needs at least 1 bit.
  localparam int CNT_W = (TIMEOUT <= 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             kill_q, kill_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       off_q, off_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             vld_q, vld_d;
  logic             fault_q, fault_d;
  logic             mis_q, mis_d;

  logic             access;
  logic             illegal;
  logic             misaligned;
  logic             timeout;
  logic             kill_now;

  // ---------------------------------------------------------------------------
  // Lane helpers
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_rep(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Request decode (only meaningful in IDLE)
  // ---------------------------------------------------------------------------
  assign access = mem_read_i | mem_write_i;

  always_comb begin
    illegal = 1'b0;
    if (mem_write_i) begin
      illegal = !(funct3_i == 3'b000 || funct3_i == 3'b001 || funct3_i == 3'b010);
    end else begin
      illegal = (funct3_i == 3'b011 || funct3_i == 3'b110 || funct3_i == 3'b111);
    end
  end

  // Half-word: H and HU share funct3[1:0] = 01. An illegal width takes
  // priority over misalignment, so the encodings overlapping here do not matter.
  assign misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                      ((funct3_i == 3'b010) && (addr_i[1:0] != 2'b00));

  // cnt_q counts REQ cycles, including the current one.
  assign timeout = (TIMEOUT != 0) && (cnt_q == TO_CNT);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    kill_d   = kill_q;
    f3_d     = f3_q;
    off_d    = off_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rdata_d  = rdata_q;
    vld_d    = 1'b0;
    fault_d  = 1'b0;
    mis_d    = 1'b0;
    stall_o  = 1'b0;
    kill_now = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (access && !flush_i) begin
          stall_o = 1'b1;
          if (illegal) begin
            fault_d = 1'b1;
            state_d = ST_DONE;
          end else if (misaligned) begin
            mis_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            we_d    = mem_write_i;
            f3_d    = funct3_i;
            off_d   = addr_i[1:0];
            addr_d  = {addr_i[31:2], 2'b00};
            be_d    = byte_en(funct3_i, addr_i[1:0]);
            wdata_d = store_rep(funct3_i, wdata_i);
            req_d   = 1'b1;
            cnt_d   = CNT_W'(1);
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        stall_o = 1'b1;
        // A flush in the completion cycle itself also has to suppress the result.
        kill_now = kill_q | flush_i;
        if (flush_i) begin
          kill_d = 1'b1;
        end
        // err beats ack, and ack beats the timeout.
        if (bus_err_i) begin
          req_d   = 1'b0;
          fault_d = !kill_now;
          state_d = ST_DONE;
        end else if (bus_ack_i) begin
          req_d   = 1'b0;
          if (!we_q && !kill_now) begin
            vld_d   = 1'b1;
            rdata_d = load_ext(bus_rdata_i, f3_q, off_q);
          end
          state_d = ST_DONE;
        end else if (timeout) begin
          req_d   = 1'b0;
          fault_d = !kill_now;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        // Request inputs still belong to the retiring instruction, so ignore them.
        kill_d  = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      kill_q  <= 1'b0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rdata_q <= 32'd0;
      vld_q   <= 1'b0;
      fault_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kill_q  <= kill_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      vld_q   <= vld_d;
      fault_q <= fault_d;
      mis_q   <= mis_d;
    end
  end

  assign bus_req_o     = req_q;
  assign bus_we_o      = we_q;
  assign bus_addr_o    = addr_q;
  assign bus_wdata_o   = wdata_q;
  assign bus_be_o      = be_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = vld_q;
  assign fault_o       = fault_q;
  assign misalign_o    = mis_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Directed testbench for mem_access_ctrl with TIMEOUT = 4.
//
// A table of load/store records is applied one transaction at a time. The
// bench checks:
//   - the bus request contents,
//   - the number of request and stall cycles,
//   - the pulses and rdata_o seen in the DONE cycle.
// Hand-written sequences cover:
//   - flush in REQ,
//   - flush in IDLE,
//   - back-to-back accesses,
//   - reset asserted mid-REQ.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b1;
  logic        mem_read_i = 1'b0;
  logic        mem_write_i = 1'b0;
  logic [2:0]  funct3_i = 3'd0;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] wdata_i = 32'd0;
  logic        flush_i = 1'b0;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        misalign_o;
  logic        fault_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_ack_i = 1'b0;
  logic        bus_err_i = 1'b0;
  logic [31:0] bus_rdata_i = 32'd0;

  mem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .mem_read_i    (mem_read_i),
    .mem_write_i   (mem_write_i),
    .funct3_i      (funct3_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .flush_i       (flush_i),
    .stall_o       (stall_o),
    .rdata_o       (rdata_o),
    .rdata_valid_o (rdata_valid_o),
    .misalign_o    (misalign_o),
    .fault_o       (fault_o),
    .bus_req_o     (bus_req_o),
    .bus_we_o      (bus_we_o),
    .bus_addr_o    (bus_addr_o),
    .bus_wdata_o   (bus_wdata_o),
    .bus_be_o      (bus_be_o),
    .bus_ack_i     (bus_ack_i),
    .bus_err_i     (bus_err_i),
    .bus_rdata_i   (bus_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_at;     // REQ cycle (1-based) carrying ack/err; 0 = never
    logic        ack;
    logic        err;
    int          exp_req;    // cycles with bus_req_o high
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
    logic        exp_vld;
    logic        exp_fault;
    logic        exp_mis;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
    input logic [31:0] wdata, input logic [31:0] rdata, input int ack_at,
    input logic ack, input logic err, input int exp_req, input logic exp_we,
    input logic [31:0] exp_addr, input logic [31:0] exp_wdata, input logic [3:0] exp_be,
    input logic exp_vld, input logic exp_fault, input logic exp_mis,
    input logic [31:0] exp_rdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.ack_at = ack_at; v.ack = ack; v.err = err; v.exp_req = exp_req; v.exp_we = exp_we;
    v.exp_addr = exp_addr; v.exp_wdata = exp_wdata; v.exp_be = exp_be;
    v.exp_vld = exp_vld; v.exp_fault = exp_fault; v.exp_mis = exp_mis;
    v.exp_rdata = exp_rdata;
    return v;
  endfunction

  task automatic clear_inputs();
    mem_read_i  = 1'b0;
    mem_write_i = 1'b0;
    funct3_i    = 3'd0;
    addr_i      = 32'd0;
    wdata_i     = 32'd0;
    flush_i     = 1'b0;
    bus_ack_i   = 1'b0;
    bus_err_i   = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  reqc;
    int  stallc;
    bit  done;
    string t;
    t = $sformatf("v%0d", idx);
    @(negedge clk_i);
    mem_read_i  = v.rd;
    mem_write_i = v.wr;
    funct3_i    = v.f3;
    addr_i      = v.addr;
    wdata_i     = v.wdata;
    flush_i     = 1'b0;
    #1;
    reqc   = 0;
    stallc = stall_o ? 1 : 0;
    done   = 0;
    for (int cyc = 1; cyc < 20 && !done; cyc++) begin
      @(negedge clk_i);
      bus_ack_i = 1'b0;
      bus_err_i = 1'b0;
      if (bus_req_o) begin
        reqc++;
        if (reqc == 1) begin
          chk({t, " we"},    {31'd0, bus_we_o},   {31'd0, v.exp_we});
          chk({t, " addr"},  bus_addr_o,          v.exp_addr);
          chk({t, " be"},    {28'd0, bus_be_o},   {28'd0, v.exp_be});
          chk({t, " wdata"}, bus_wdata_o,         v.exp_wdata);
        end
        if (v.ack_at != 0 && reqc == v.ack_at) begin
          bus_ack_i   = v.ack;
          bus_err_i   = v.err;
          bus_rdata_i = v.rdata;
        end
      end
      #1;
      if (stall_o) begin
        stallc++;
      end else begin
        done = 1;
        chk({t, " rdata_valid"}, {31'd0, rdata_valid_o}, {31'd0, v.exp_vld});
        chk({t, " fault"},       {31'd0, fault_o},       {31'd0, v.exp_fault});
        chk({t, " misalign"},    {31'd0, misalign_o},    {31'd0, v.exp_mis});
        chk({t, " rdata"},       rdata_o,                v.exp_rdata);
        chk({t, " req_cycles"},  reqc,                   v.exp_req);
        chk({t, " stall_cycles"}, stallc,                v.exp_req + 1);
      end
    end
    if (!done) chk({t, " completion"}, 32'd0, 32'd1);
    clear_inputs();
    @(negedge clk_i);
    #1;
    chk({t, " idle pulses"}, {29'd0, rdata_valid_o, fault_o, misalign_o}, 32'd0);
    chk({t, " idle req"},    {31'd0, bus_req_o}, 32'd0);
  endtask

  // Flush during REQ. The ack (or err) in the second REQ cycle must be consumed
  // silently, and rdata_o must keep prev.
  task automatic flush_seq(input logic use_err, input logic [31:0] prev);
    @(negedge clk_i);
    mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h0000_0100;
    @(negedge clk_i);
    flush_i = 1'b1;
    #1 chk("flush req1", {31'd0, bus_req_o}, 32'd1);
    @(negedge clk_i);
    flush_i = 1'b0;
    bus_ack_i = ~use_err; bus_err_i = use_err; bus_rdata_i = 32'h1111_1111;
    #1 chk("flush req2 stall", {31'd0, stall_o}, 32'd1);
    @(negedge clk_i);
    bus_ack_i = 1'b0; bus_err_i = 1'b0;
    #1;
    chk("flush done stall", {31'd0, stall_o}, 32'd0);
    chk("flush no valid",   {31'd0, rdata_valid_o}, 32'd0);
    chk("flush no fault",   {31'd0, fault_o}, 32'd0);
    chk("flush rdata hold", rdata_o, prev);
    clear_inputs();
    @(negedge clk_i);
    #1 chk("flush idle pulses", {30'd0, rdata_valid_o, fault_o}, 32'd0);
  endtask

  initial begin
    //     rd wr f3     addr          wdata         rdata        at ack err req we eaddr         ewdata        be     vld flt mis erdata
    vecs.push_back(mk(1, 0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 3, 1, 0, 3, 0, 32'h0000_0100, 32'h0,        4'b1111, 1, 0, 0, 32'hDEAD_BEEF));
    vecs.push_back(mk(1, 0, 3'b000, 32'h0000_0103, 32'h0,        32'h80AA_55CC, 1, 1, 0, 1, 0, 32'h0000_0100, 32'h0,        4'b1000, 1, 0, 0, 32'hFFFF_FF80));
    vecs.push_back(mk(1, 0, 3'b100, 32'h0000_0103, 32'h0,        32'h80AA_55CC, 1, 1, 0, 1, 0, 32'h0000_0100, 32'h0,        4'b1000, 1, 0, 0, 32'h0000_0080));
    vecs.push_back(mk(1, 0, 3'b001, 32'h0000_0102, 32'h0,        32'h80AA_55CC, 2, 1, 0, 2, 0, 32'h0000_0100, 32'h0,        4'b1100, 1, 0, 0, 32'hFFFF_80AA));
    vecs.push_back(mk(1, 0, 3'b101, 32'h0000_0100, 32'h0,        32'h80AA_55CC, 1, 1, 0, 1, 0, 32'h0000_0100, 32'h0,        4'b0011, 1, 0, 0, 32'h0000_55CC));
    vecs.push_back(mk(1, 0, 3'b000, 32'h0000_0101, 32'h0,        32'h80AA_55CC, 1, 1, 0, 1, 0, 32'h0000_0100, 32'h0,        4'b0010, 1, 0, 0, 32'h0000_0055));
    vecs.push_back(mk(0, 1, 3'b001, 32'h0000_0202, 32'h0000_1234, 32'h0,        1, 1, 0, 1, 1, 32'h0000_0200, 32'h1234_1234, 4'b1100, 0, 0, 0, 32'h0000_0055));
    vecs.push_back(mk(0, 1, 3'b000, 32'h0000_0001, 32'hABCD_EF5A, 32'h0,        2, 1, 0, 2, 1, 32'h0000_0000, 32'h5A5A_5A5A, 4'b0010, 0, 0, 0, 32'h0000_0055));
    vecs.push_back(mk(0, 1, 3'b010, 32'h0000_0304, 32'hCAFE_F00D, 32'h0,        1, 1, 0, 1, 1, 32'h0000_0304, 32'hCAFE_F00D, 4'b1111, 0, 0, 0, 32'h0000_0055));
    vecs.push_back(mk(1, 0, 3'b010, 32'h0000_0102, 32'h0,        32'h0,         0, 0, 0, 0, 0, 32'h0,         32'h0,        4'b0000, 0, 0, 1, 32'h0000_0055));
    vecs.push_back(mk(1, 0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,         0, 0, 0, 0, 0, 32'h0,         32'h0,        4'b0000, 0, 1, 0, 32'h0000_0055));
    vecs.push_back(mk(0, 1, 3'b100, 32'h0000_0100, 32'h0,        32'h0,         0, 0, 0, 0, 0, 32'h0,         32'h0,        4'b0000, 0, 1, 0, 32'h0000_0055));
    vecs.push_back(mk(0, 1, 3'b101, 32'h0000_0001, 32'h0,        32'h0,         0, 0, 0, 0, 0, 32'h0,         32'h0,        4'b0000, 0, 1, 0, 32'h0000_0055));
    vecs.push_back(mk(1, 0, 3'b001, 32'h0000_0101, 32'h0,        32'h0,         0, 0, 0, 0, 0, 32'h0,         32'h0,        4'b0000, 0, 0, 1, 32'h0000_0055));
    vecs.push_back(mk(0, 1, 3'b001, 32'h0000_0203, 32'h0,        32'h0,         0, 0, 0, 0, 0, 32'h0,         32'h0,        4'b0000, 0, 0, 1, 32'h0000_0055));
    vecs.push_back(mk(1, 0, 3'b010, 32'h0000_0108, 32'h0,        32'h1234_5678, 2, 0, 1, 2, 0, 32'h0000_0108, 32'h0,        4'b1111, 0, 1, 0, 32'h0000_0055));
    vecs.push_back(mk(1, 0, 3'b010, 32'h0000_010C, 32'h0,        32'h1234_5678, 1, 1, 1, 1, 0, 32'h0000_010C, 32'h0,        4'b1111, 0, 1, 0, 32'h0000_0055));
    vecs.push_back(mk(1, 0, 3'b010, 32'h0000_0110, 32'h0,        32'h0,         0, 0, 0, 4, 0, 32'h0000_0110, 32'h0,        4'b1111, 0, 1, 0, 32'h0000_0055));
    vecs.push_back(mk(1, 1, 3'b010, 32'h0000_0010, 32'h1122_3344, 32'h0,        1, 1, 0, 1, 1, 32'h0000_0010, 32'h1122_3344, 4'b1111, 0, 0, 0, 32'h0000_0055));
    vecs.push_back(mk(1, 0, 3'b101, 32'h0000_0102, 32'h0,        32'hFEDC_0000, 1, 1, 0, 1, 0, 32'h0000_0100, 32'h0,        4'b1100, 1, 0, 0, 32'h0000_FEDC));

    // Reset
    #2 rst_n_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    chk("reset stall",  {31'd0, stall_o}, 32'd0);
    chk("reset req",    {31'd0, bus_req_o}, 32'd0);
    chk("reset pulses", {29'd0, rdata_valid_o, fault_o, misalign_o}, 32'd0);
    chk("reset bus",    {bus_addr_o[31:5], bus_be_o, bus_we_o} | bus_wdata_o, 32'd0);
    chk("reset rdata",  rdata_o, 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], i);
    end

    flush_seq(1'b0, 32'h0000_FEDC);
    flush_seq(1'b1, 32'h0000_FEDC);

    // Flush in IDLE: nothing starts
    @(negedge clk_i);
    mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h0000_0100; flush_i = 1'b1;
    #1 chk("idle flush stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk_i);
    #1 chk("idle flush req", {31'd0, bus_req_o}, 32'd0);
    clear_inputs();

    // Back-to-back: request held continuously, so one bus cycle every 3 clocks
    @(negedge clk_i);
    mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h0000_0100;
    #1 chk("b2b c0 stall", {31'd0, stall_o}, 32'd1);
    @(negedge clk_i);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h0A0B_0C0D;
    #1 chk("b2b c1 req", {31'd0, bus_req_o}, 32'd1);
    @(negedge clk_i);
    bus_ack_i = 1'b0;
    #1;
    chk("b2b c2 stall/req", {30'd0, stall_o, bus_req_o}, 32'd0);
    chk("b2b c2 valid", {31'd0, rdata_valid_o}, 32'd1);
    chk("b2b c2 rdata", rdata_o, 32'h0A0B_0C0D);
    @(negedge clk_i);
    #1 chk("b2b c3 stall/req", {30'd0, stall_o, bus_req_o}, 32'd2);
    @(negedge clk_i);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h5060_7080;
    #1 chk("b2b c4 req", {31'd0, bus_req_o}, 32'd1);
    @(negedge clk_i);
    clear_inputs();
    #1 chk("b2b c5 rdata", rdata_o, 32'h5060_7080);

    // Reset asserted mid-REQ
    @(negedge clk_i);
    mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h0000_0104;
    @(negedge clk_i);
    #1 chk("rst mid req before", {31'd0, bus_req_o}, 32'd1);
    rst_n_i = 1'b0;
    mem_read_i = 1'b0;
    #1;
    chk("rst mid req", {31'd0, bus_req_o}, 32'd0);
    chk("rst mid outs", {28'd0, stall_o, rdata_valid_o, fault_o, misalign_o}, 32'd0);
    chk("rst mid bus", bus_addr_o | bus_wdata_o | {27'd0, bus_be_o, bus_we_o}, 32'd0);
    chk("rst mid rdata", rdata_o, 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    clear_inputs();
    @(negedge clk_i);
    #1 chk("post rst idle", {29'd0, stall_o, bus_req_o, fault_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
